fp_div_wb: RTL and testbench
============================

// Module: fp_div_wb
// PURPOSE
//  Writeback stage directly downstream of the combinational double-precision divider.
//  Captures the divider's quotient together with the operands that produced it.
//  Saturates exponent overflow/underflow, which the divider wraps, to +/-Inf or +/-0.
//  Generates IEEE exception flags, buffers results in a valid/ready FIFO, and keeps a
//  sticky flag register.
// PARAMETERS
//  DEPTH  2  FIFO entries; power of 2, >=2
//  TAG_W  4  width of the opaque request tag carried alongside each result
// PORTS
//  clk         in   1      rising-edge clock (single clock domain)
//  rst_n       in   1      synchronous active-low reset
//  in_valid    in   1      divider output valid
//  in_ready    out  1      stage can accept; = !full
//  in_a        in   64     dividend presented to divider
//  in_b        in   64     divisor presented to divider
//  in_q        in   64     divider quotient for in_a/in_b
//  in_tag      in   TAG_W  request tag
//  out_valid   out  1      head entry valid
//  out_ready   in   1      consumer accepts head
//  out_result  out  64     corrected quotient
//  out_flags   out  4      {NV,DZ,OF,UF} for head entry
//  out_tag     out  TAG_W  tag of head entry
//  fflags      out  4      sticky {NV,DZ,OF,UF}
//  fflags_clr  in   1      clear sticky flags
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): FIFO emptied; count=0; fflags=0; out_valid=0;
//   in_ready=1. out_result, out_flags and out_tag read 0 while empty.
//  Accept on in_valid&&in_ready; release on out_valid&&out_ready.
//  Entry is visible at out_valid exactly 1 cycle after accept; no combinational bypass.
//  Handshake rules:
//   - in_ready = (count!=DEPTH). No push while full, even if a pop occurs that cycle.
//   - Push and pop in the same cycle: count unchanged, order preserved.
//   - Pointers wrap modulo DEPTH.
//  Correction, combinational on inputs, applied before the write:
//   - Class of each operand: zero (exp=0, frac=0), inf (exp=7FF, frac=0),
//     nan (exp=7FF, frac!=0).
//   - NV = nan_a | nan_b | (zero_a&zero_b) | (inf_a&inf_b); result = in_q (0x7FF8000000000000).
//   - DZ = zero_b & ~zero_a & ~nan_a & ~inf_a; result = in_q.
//   - Any other special operand: result = in_q, flags = 0.
//   - Normal path (no specials):
//       ea = exp_a ? exp_a : 1;  eb = exp_b ? exp_b : 1.
//       e  = ea - eb + 1023 - (ma<mb), computed signed 13-bit,
//       where ma={exp_a!=0,frac_a} and mb={exp_b!=0,frac_b}.
//   - e>=2047: OF=1, result = {sign,7FF,52'b0}.
//   - e<=0: UF=1, result = {sign,63'b0}, flush to zero (no subnormal output).
//   - Otherwise: result = in_q, flags = 0.
//   - sign = a[63]^b[63].
//  Sticky flags:
//   - On release, fflags |= out_flags.
//   - fflags_clr alone: fflags <= 0.
//   - fflags_clr with a release in the same cycle: fflags <= out_flags of the released
//     entry (the new flags survive the clear).
//  Reset mid-operation discards all buffered entries; no output handshake completes in
//  that cycle.
//  Out-side behaviour:
//   - out_* is stable while out_valid && !out_ready.
//   - in_* is sampled only on accept.
// TESTING
//  T1 6.0/2.0: a=4018000000000000, b=4000000000000000, q=4008000000000000
//     -> out_result 4008000000000000, flags 0000, 1-cycle latency.
//  T2 1/0: a=3FF0000000000000, b=0, q=7FF0000000000000 -> result 7FF0000000000000,
//     flags 0100. Then 0/0 -> 7FF8000000000000, flags 1000.
//     fflags=1100 after both are released.
//  T3 overflow: a=7FE0000000000000, b=3FE0000000000000 (e=2047), any q
//     -> result 7FF0000000000000, flags 0010.
//  T4 underflow: a=0010000000000000, b=4000000000000000 (e=0), any q
//     -> result 0000000000000000, flags 0001. Sign check: a negated -> 8000000000000000.
//  T5 backpressure: out_ready=0; push DEPTH entries tagged 0..DEPTH-1 -> in_ready=0
//     and an extra in_valid is not taken; raise out_ready -> tags drain in order;
//     full + push + pop in the same cycle -> push refused.
//  T6 fflags_clr coincident with releasing a DZ entry -> fflags=0100.
//     rst_n=0 with 2 entries queued -> next cycle out_valid=0, fflags=0, in_ready=1.

Source files
------------

// File: rtl/fp_div_wb.sv
// Writeback stage behind the combinational double divider: saturates wrapped exponents,
// raises {NV,DZ,OF,UF}, queues results in a small valid/ready FIFO, keeps sticky flags.
module fp_div_wb #(
   parameter int DEPTH = 2,
   parameter int TAG_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [63:0]      in_a,
   input  logic [63:0]      in_b,
   input  logic [63:0]      in_q,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [63:0]      out_result,
   output logic [3:0]       out_flags,
   output logic [TAG_W-1:0] out_tag,
   output logic [3:0]       fflags,
   input  logic             fflags_clr
);
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic [10:0]        exp_a, exp_b;
   logic [51:0]        frac_a, frac_b;
   logic               zero_a, zero_b, inf_a, inf_b, nan_a, nan_b;
   logic               special, sign, nv, dz, mant_lt;
   logic [10:0]        ea, eb;
   logic signed [12:0] e;
   logic [63:0]        corr_result;
   logic [3:0]         corr_flags;

   assign exp_a  = in_a[62:52];
   assign exp_b  = in_b[62:52];
   assign frac_a = in_a[51:0];
   assign frac_b = in_b[51:0];
   assign zero_a = (exp_a == 11'd0) && (frac_a == 52'd0);
   assign zero_b = (exp_b == 11'd0) && (frac_b == 52'd0);
   assign inf_a  = (exp_a == 11'h7FF) && (frac_a == 52'd0);
   assign inf_b  = (exp_b == 11'h7FF) && (frac_b == 52'd0);
   assign nan_a  = (exp_a == 11'h7FF) && (frac_a != 52'd0);
   assign nan_b  = (exp_b == 11'h7FF) && (frac_b != 52'd0);
   assign special = zero_a | zero_b | inf_a | inf_b | nan_a | nan_b;
   assign sign   = in_a[63] ^ in_b[63];
   assign nv     = nan_a | nan_b | (zero_a & zero_b) | (inf_a & inf_b);
   assign dz     = zero_b & ~zero_a & ~nan_a & ~inf_a;

   // Subnormal operands use an effective exponent of 1 with no hidden bit.
   assign ea      = (exp_a != 11'd0) ? exp_a : 11'd1;
   assign eb      = (exp_b != 11'd0) ? exp_b : 11'd1;
   assign mant_lt = {exp_a != 11'd0, frac_a} < {exp_b != 11'd0, frac_b};
   assign e       = $signed({2'b00, ea}) - $signed({2'b00, eb}) + 13'sd1023
                    - $signed({12'd0, mant_lt});

   always_comb begin
      corr_result = in_q;
      corr_flags  = 4'b0000;
      if (special) begin
         corr_flags = {nv, dz, 2'b00};
      end else if (e >= 13'sd2047) begin
         corr_result = {sign, 11'h7FF, 52'd0};
         corr_flags  = 4'b0010;
      end else if (e <= 13'sd0) begin
         corr_result = {sign, 63'd0};
         corr_flags  = 4'b0001;
      end
   end

   logic [63:0]      mem_result [DEPTH];
   logic [3:0]       mem_flags  [DEPTH];
   logic [TAG_W-1:0] mem_tag    [DEPTH];
   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic [CNT_W-1:0] count;
   logic             push, pop;

   assign in_ready  = (count != CNT_W'(DEPTH));
   assign out_valid = (count != '0);
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;

   assign out_result = out_valid ? mem_result[rd_ptr] : 64'd0;
   assign out_flags  = out_valid ? mem_flags[rd_ptr]  : 4'd0;
   assign out_tag    = out_valid ? mem_tag[rd_ptr]    : '0;

   always_ff @(posedge clk) begin
      if (push) begin
         mem_result[wr_ptr] <= corr_result;
         mem_flags[wr_ptr]  <= corr_flags;
         mem_tag[wr_ptr]    <= in_tag;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         fflags <= 4'd0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
         // Flags of an entry released during a clear survive the clear.
         if (pop)
            fflags <= (fflags_clr ? 4'd0 : fflags) | out_flags;
         else if (fflags_clr)
            fflags <= 4'd0;
      end
   end
endmodule

// File: tb/tb_fp_div_wb.sv
// Directed bench for fp_div_wb: special-operand flags, exponent saturation,
// FIFO backpressure/ordering, sticky flag clear and mid-operation reset.
module tb_fp_div_wb;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [63:0] in_a, in_b, in_q;
   logic [3:0]  in_tag;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] out_result;
   logic [3:0]  out_flags;
   logic [3:0]  out_tag;
   logic [3:0]  fflags;
   logic        fflags_clr;

   int n_chk  = 0;
   int n_pass = 0;

   fp_div_wb #(.DEPTH(2), .TAG_W(4)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_a       (in_a),
      .in_b       (in_b),
      .in_q       (in_q),
      .in_tag     (in_tag),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_result (out_result),
      .out_flags  (out_flags),
      .out_tag    (out_tag),
      .fflags     (fflags),
      .fflags_clr (fflags_clr)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] q, input logic [3:0] t);
      in_a = a; in_b = b; in_q = q; in_tag = t; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic pop();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   task automatic clear_flags();
      fflags_clr = 1'b1;
      tick();
      fflags_clr = 1'b0;
   endtask

   localparam logic [63:0] A6 = 64'h4018000000000000;
   localparam logic [63:0] B2 = 64'h4000000000000000;
   localparam logic [63:0] Q3 = 64'h4008000000000000;

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; fflags_clr = 1'b0;
      in_a = '0; in_b = '0; in_q = '0; in_tag = '0;
      tick(); tick();
      rst_n = 1'b1;
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_in_ready",  64'(in_ready),  64'd1);
      check("rst_fflags",    64'(fflags),    64'd0);
      check("rst_result",    out_result,     64'd0);
      check("rst_flags",     64'(out_flags), 64'd0);
      check("rst_tag",       64'(out_tag),   64'd0);

      // T1: 6.0 / 2.0, one-cycle latency
      push(A6, B2, Q3, 4'd7);
      check("t1_valid",  64'(out_valid), 64'd1);
      check("t1_result", out_result,     Q3);
      check("t1_flags",  64'(out_flags), 64'd0);
      check("t1_tag",    64'(out_tag),   64'd7);
      pop();
      check("t1_empty",  64'(out_valid), 64'd0);

      // T2: 1/0 then 0/0
      push(64'h3FF0000000000000, 64'd0, 64'h7FF0000000000000, 4'd1);
      push(64'd0, 64'd0, 64'h7FF8000000000000, 4'd2);
      check("t2_dz_result", out_result,     64'h7FF0000000000000);
      check("t2_dz_flags",  64'(out_flags), 64'b0100);
      pop();
      check("t2_nv_result", out_result,     64'h7FF8000000000000);
      check("t2_nv_flags",  64'(out_flags), 64'b1000);
      pop();
      check("t2_fflags",    64'(fflags),    64'b1100);
      clear_flags();
      check("clr_fflags",   64'(fflags),    64'd0);

      // T3: overflow saturates to +Inf
      push(64'h7FE0000000000000, 64'h3FE0000000000000, 64'h0123456789ABCDEF, 4'd3);
      check("t3_result", out_result,     64'h7FF0000000000000);
      check("t3_flags",  64'(out_flags), 64'b0010);
      pop();

      // T4: underflow flushes to signed zero
      push(64'h0010000000000000, B2, 64'h0123456789ABCDEF, 4'd4);
      check("t4_result", out_result,     64'd0);
      check("t4_flags",  64'(out_flags), 64'b0001);
      pop();
      push(64'h8010000000000000, B2, 64'h0123456789ABCDEF, 4'd5);
      check("t4_neg_result", out_result,     64'h8000000000000000);
      check("t4_neg_flags",  64'(out_flags), 64'b0001);
      pop();
      check("t4_fflags",     64'(fflags),    64'b0011);
      clear_flags();

      // T5: backpressure and ordering
      push(A6, B2, Q3, 4'd0);
      push(A6, B2, Q3, 4'd1);
      check("t5_full_ready", 64'(in_ready), 64'd0);
      push(A6, B2, Q3, 4'd9);
      check("t5_extra_head", 64'(out_tag),  64'd0);
      check("t5_still_full", 64'(in_ready), 64'd0);
      in_a = A6; in_b = B2; in_q = Q3; in_tag = 4'd6; in_valid = 1'b1; out_ready = 1'b1;
      tick();
      in_valid = 1'b0; out_ready = 1'b0;
      check("t5_pp_head",  64'(out_tag),   64'd1);
      check("t5_pp_ready", 64'(in_ready),  64'd1);
      pop();
      check("t5_drained",  64'(out_valid), 64'd0);
      push(A6, B2, Q3, 4'd3);
      in_a = A6; in_b = B2; in_q = Q3; in_tag = 4'd4; in_valid = 1'b1; out_ready = 1'b1;
      tick();
      in_valid = 1'b0; out_ready = 1'b0;
      check("t5_pp1_valid", 64'(out_valid), 64'd1);
      check("t5_pp1_tag",   64'(out_tag),   64'd4);
      check("t5_pp1_ready", 64'(in_ready),  64'd1);
      pop();
      check("t5_pp1_empty", 64'(out_valid), 64'd0);

      // T6: clear coincident with DZ release, then reset with entries queued
      push(64'h7FE0000000000000, 64'h3FE0000000000000, Q3, 4'd2);
      pop();
      check("t6_pre_fflags", 64'(fflags), 64'b0010);
      push(64'h3FF0000000000000, 64'd0, 64'h7FF0000000000000, 4'd8);
      fflags_clr = 1'b1; out_ready = 1'b1;
      tick();
      fflags_clr = 1'b0; out_ready = 1'b0;
      check("t6_clr_pop_fflags", 64'(fflags), 64'b0100);
      push(A6, B2, Q3, 4'd10);
      push(A6, B2, Q3, 4'd11);
      check("t6_pre_rst_full", 64'(in_ready), 64'd0);
      rst_n = 1'b0; out_ready = 1'b1;
      tick();
      rst_n = 1'b1; out_ready = 1'b0;
      check("t6_rst_valid",  64'(out_valid), 64'd0);
      check("t6_rst_fflags", 64'(fflags),    64'd0);
      check("t6_rst_ready",  64'(in_ready),  64'd1);
      check("t6_rst_result", out_result,     64'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
